// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Results are computed at Start and committed after a fixed latency.
module md_unit (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [1:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiWe,
   input  logic        LoWe,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rhi_q, rhi_d;
   logic [31:0] rlo_q, rlo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        bz_q, bz_d;

   logic        sgn;
   logic [63:0] ax, bx, prod;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [31:0] q_mag, r_mag;
   logic [31:0] quo, rem;

   // operand conditioning, product and signed-magnitude divide
   always_comb begin
      sgn   = ~MDOp[0];
      ax    = {{32{A[31] & sgn}}, A};
      bx    = {{32{B[31] & sgn}}, B};
      prod  = ax * bx;
      a_neg = sgn & A[31];
      b_neg = sgn & B[31];
      a_mag = a_neg ? (~A + 32'd1) : A;
      b_mag = b_neg ? (~B + 32'd1) : B;
      q_mag = 32'd0;
      r_mag = 32'd0;
      if (b_mag != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   // next-state, counter and HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rhi_d   = rhi_q;
      rlo_d   = rlo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      bz_d    = bz_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               bz_d = 1'b0;
               if (!MDOp[1]) begin
                  rhi_d   = prod[63:32];
                  rlo_d   = prod[31:0];
                  cnt_d   = 4'd4;
                  state_d = MUL;
               end else begin
                  rhi_d   = rem;
                  rlo_d   = quo;
                  bz_d    = (B == 32'd0);
                  cnt_d   = 4'd9;
                  state_d = DIV;
               end
            end else begin
               if (HiWe) hi_d = A;
               if (LoWe) lo_d = A;
            end
         end
         MUL, DIV: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
               if (!(state_q == DIV && bz_q)) begin
                  hi_d = rhi_q;
                  lo_d = rlo_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // state registers, cleared asynchronously
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rhi_q   <= 32'd0;
         rlo_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         bz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rhi_q   <= rhi_d;
         rlo_q   <= rlo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         bz_q    <= bz_d;
      end
   end

   assign Busy = (state_q != IDLE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Expected HI/LO come from a behavioural model queued at Start.
module tb_md_unit;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [1:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        HiWe;
   logic        LoWe;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   logic [63:0] sbq[$];
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   md_unit dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .Start(Start),
      .MDOp (MDOp),
      .A    (A),
      .B    (B),
      .HiWe (HiWe),
      .LoWe (LoWe),
      .Busy (Busy),
      .HI   (HI),
      .LO   (LO)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [31:0] uq, ur;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         2'b00: model = sa * sb;
         2'b01: model = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) model = {exp_hi, exp_lo};
            else begin
               q = sa / sb;
               r = sa % sb;
               model = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) model = {exp_hi, exp_lo};
            else begin
               uq = a / b;
               ur = a % b;
               model = {ur, uq};
            end
         end
      endcase
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hiwe,
                         input int inj_at, input int rst_at);
      logic [63:0] e;
      logic [63:0] got;
      logic [31:0] old_hi, old_lo;
      int n;
      int lat;
      old_hi = exp_hi;
      old_lo = exp_lo;
      e = model(op, a, b);
      sbq.push_back(e);
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      lat = op[1] ? 10 : 5;
      Start = 1'b1;
      MDOp  = op;
      A     = a;
      B     = b;
      HiWe  = hiwe;
      @(negedge Clk);
      Start = 1'b0;
      HiWe  = 1'b0;
      n = 0;
      while (Busy && n < 40) begin
         n++;
         chk("hold_hi", HI, old_hi);
         chk("hold_lo", LO, old_lo);
         if (n == inj_at) begin
            Start = 1'b1;
            MDOp  = 2'b11;
            A     = 32'h1234;
            B     = 32'd1;
            LoWe  = 1'b1;
         end else begin
            Start = 1'b0;
            LoWe  = 1'b0;
         end
         if (n == rst_at) begin
            #2 Rst = 1'b0;
            #1;
            chk("rst_busy", {31'd0, Busy}, 32'd0);
            chk("rst_hi", HI, 32'd0);
            chk("rst_lo", LO, 32'd0);
            sbq.delete();
            exp_hi = 32'd0;
            exp_lo = 32'd0;
            @(negedge Clk);
            Rst = 1'b1;
            return;
         end
         @(negedge Clk);
      end
      Start = 1'b0;
      LoWe  = 1'b0;
      chk("latency", n, lat);
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         got = {HI, LO};
         e = sbq.pop_front();
         chk("res_hi", got[63:32], e[63:32]);
         chk("res_lo", got[31:0], e[31:0]);
      end
   endtask

   initial begin
      Rst   = 1'b1;
      Start = 1'b0;
      MDOp  = 2'b00;
      A     = 32'd0;
      B     = 32'd0;
      HiWe  = 1'b0;
      LoWe  = 1'b0;
      #2 Rst = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      Rst = 1'b1;

      run_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 0);
      run_op(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0);
      run_op(2'b11, 32'd7, 32'd0, 1'b0, 0, 0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 0, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 0, 0);
      run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0);
      run_op(2'b00, 32'h00012345, 32'h00054321, 1'b0, 2, 0);

      HiWe = 1'b1;
      LoWe = 1'b1;
      A    = 32'hABCD;
      @(negedge Clk);
      HiWe = 1'b0;
      LoWe = 1'b0;
      exp_hi = 32'hABCD;
      exp_lo = 32'hABCD;
      chk("wr_hi", HI, 32'hABCD);
      chk("wr_lo", LO, 32'hABCD);
      HiWe = 1'b1;
      A    = 32'h5555;
      @(negedge Clk);
      HiWe = 1'b0;
      exp_hi = 32'h5555;
      chk("wr_hi_only", HI, 32'h5555);
      chk("wr_lo_keep", LO, 32'hABCD);

      run_op(2'b00, 32'd3, 32'd4, 1'b1, 0, 0);

      run_op(2'b10, 32'd100, 32'd7, 1'b0, 0, 4);
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 0, 0);

      for (int i = 0; i < 8; i++) begin
         logic [1:0]  op;
         logic [31:0] ra, rb;
         op = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : $urandom;
         if (i[0]) rb = rb >> 20;
         run_op(op, ra, rb, 1'b0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
